// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared state encodings and stop-cause codes for the clock controller
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_HALT  = 2'd1;
    localparam logic [1:0] CAUSE_LIMIT = 2'd2;
    localparam logic [1:0] CAUSE_HLT   = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clear beats increment
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    // next count: clear first, otherwise increment unless already saturated
    always_comb begin
        count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + WIDTH'(1) : count_q;
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/clock_control.sv
// clock_control: run/step/halt controller producing a registered core clock enable
module clock_control
    import clock_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int LIM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             halt,
    input  logic             halt_instr,
    input  logic [LIM_W-1:0] cycle_limit,
    input  logic             clear_count,
    output logic             clock_enable,
    output logic             busy,
    output logic             done,
    output logic [1:0]       stop_cause,
    output logic [CNT_W-1:0] cycle_count
);

    state_t           state_q, state_d;
    logic [LIM_W-1:0] lim_q, lim_d;
    logic [LIM_W-1:0] run_q, run_d;
    logic [1:0]       cause_q, cause_d;
    logic             ce_q, ce_d;
    logic             done_q, done_d;

    // next state: IDLE accepts commands (halt masks all), RUN stops on halt > HLT > limit
    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        run_d   = run_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (!halt && step) begin
                    state_d = ST_STEP;
                    cause_d = CAUSE_NONE;
                end else if (!halt && start) begin
                    state_d = ST_RUN;
                    lim_d   = cycle_limit;
                    run_d   = '0;
                    cause_d = CAUSE_NONE;
                end
            end
            ST_STEP: state_d = ST_IDLE;
            ST_RUN: begin
                run_d = run_q + LIM_W'(1);
                if (halt) begin
                    state_d = ST_IDLE;
                    cause_d = CAUSE_HALT;
                end else if (halt_instr) begin
                    state_d = ST_IDLE;
                    cause_d = CAUSE_HLT;
                end else if (lim_q != '0 && run_q == lim_q - LIM_W'(1)) begin
                    state_d = ST_IDLE;
                    cause_d = CAUSE_LIMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ce_d   = state_d != ST_IDLE;
        done_d = state_q != ST_IDLE && state_d == ST_IDLE;
    end

    // control registers; reset drops the enable immediately and suppresses done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lim_q   <= '0;
            run_q   <= '0;
            cause_q <= CAUSE_NONE;
            ce_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            run_q   <= run_d;
            cause_q <= cause_d;
            ce_q    <= ce_d;
            done_q  <= done_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ce_q),
        .clr   (clear_count),
        .count (cycle_count)
    );

    assign clock_enable = ce_q;
    assign busy         = state_q != ST_IDLE;
    assign done         = done_q;
    assign stop_cause   = cause_q;

endmodule

// File: tb/tb_clock_control.sv
// tb_clock_control: transaction-level checks of run/step/halt behaviour against expected cycle budgets
module tb_clock_control;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        start = 1'b0, step = 1'b0, halt = 1'b0, halt_instr = 1'b0, clear_count = 1'b0;
    logic [15:0] cycle_limit = '0;
    logic        ce, busy, done, ce4, busy4, done4;
    logic [1:0]  cause, cause4;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    int          checks = 0, errors = 0;
    int          total = 0;
    int          last_cause = 0;

    always #5 clk = ~clk;

    clock_control dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .halt(halt),
        .halt_instr(halt_instr), .cycle_limit(cycle_limit), .clear_count(clear_count),
        .clock_enable(ce), .busy(busy), .done(done), .stop_cause(cause), .cycle_count(cnt)
    );

    clock_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .halt(halt),
        .halt_instr(halt_instr), .cycle_limit(cycle_limit), .clear_count(clear_count),
        .clock_enable(ce4), .busy(busy4), .done(done4), .stop_cause(cause4), .cycle_count(cnt4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt"}, cnt, total);
        check({tag, "_cnt4"}, cnt4, total > 15 ? 15 : total);
    endtask

    // One command; *_at give the enabled-cycle index at which a pulse is driven (0 = never)
    task automatic run_cmd(input bit is_step, input bit both, input int limit, input int halt_at,
                           input int hlt_at, input int clr_at, input bit poke);
        int exp_en, exp_cause, en, busy_n;
        bit seen;
        en = 0; busy_n = 0; seen = 0;
        if (is_step) begin
            exp_en = 1;
            exp_cause = 0;
        end else begin
            exp_en = 100000;
            if (limit > 0) exp_en = limit;
            if (halt_at > 0 && halt_at < exp_en) exp_en = halt_at;
            if (hlt_at > 0 && hlt_at < exp_en) exp_en = hlt_at;
            exp_cause = (halt_at == exp_en) ? 1 : (hlt_at == exp_en) ? 3 : 2;
        end
        @(negedge clk);
        cycle_limit = 16'(limit);
        start = !is_step || both;
        step = is_step;
        @(negedge clk);
        start = 0;
        step = 0;
        for (int t = 0; t < 300 && !seen; t++) begin
            if (done) seen = 1;
            else begin
                if (ce) en++;
                if (busy) busy_n++;
                halt = ce && en == halt_at;
                halt_instr = ce && en == hlt_at;
                clear_count = ce && en == clr_at;
                start = poke && ce && en == 2;
                step = poke && ce && en == 3;
                @(negedge clk);
            end
        end
        check("ce_at_done", ce, 0);
        {halt, halt_instr, clear_count, start, step} = '0;
        if (clr_at > 0 && clr_at <= exp_en) total = exp_en - clr_at;
        else total += exp_en;
        check("done_seen", seen, 1);
        check("en_cycles", en, exp_en);
        check("busy_cycles", busy_n, exp_en);
        check("cause", cause, exp_cause);
        check("cause4", cause4, exp_cause);
        check_counts("run");
        last_cause = exp_cause;
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    // Commands with halt in IDLE must do nothing; halt_instr is unqualified while disabled
    task automatic idle_noop();
        @(negedge clk);
        halt = 1; start = 1; halt_instr = 1;
        @(negedge clk);
        {halt, start, halt_instr} = '0;
        for (int i = 0; i < 3; i++) begin
            check("noop_ce", ce, 0);
            check("noop_done", done, 0);
            @(negedge clk);
        end
        check("noop_cause", cause, last_cause);
        check_counts("noop");
    endtask

    task automatic clear_idle();
        @(negedge clk);
        clear_count = 1;
        @(negedge clk);
        clear_count = 0;
        total = 0;
        check_counts("clr_idle");
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        cycle_limit = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        check("rst_pre_ce", ce, 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_ce", ce, 0);
        check("rst_ce4", ce4, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cause", cause, 0);
        total = 0;
        check_counts("rst");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_hold_done", done, 0);
            check("rst_hold_ce", ce, 0);
        end
        rst_n = 1;
        last_cause = 0;
        repeat (2) @(negedge clk);
        check("rst_after_done", done, 0);
        check("rst_after_ce", ce, 0);
    endtask

    initial begin
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        check("init_ce", ce, 0);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_cause", cause, 0);
        check_counts("init");
        rst_n = 1;
        @(negedge clk);
        run_cmd(0, 0, 5, 0, 0, 0, 0);
        run_cmd(1, 0, 0, 0, 0, 0, 0);
        run_cmd(0, 0, 0, 0, 7, 0, 1);
        run_cmd(0, 0, 0, 4, 4, 0, 1);
        run_cmd(0, 0, 3, 3, 0, 0, 0);
        run_cmd(0, 0, 6, 0, 6, 0, 0);
        run_cmd(0, 0, 1, 0, 0, 0, 0);
        run_cmd(1, 1, 9, 1, 0, 0, 0);
        idle_noop();
        clear_idle();
        run_cmd(0, 0, 20, 0, 0, 0, 0);
        run_cmd(0, 0, 5, 0, 0, 5, 0);
        for (int r = 0; r < 24; r++) begin
            bit is_step;
            int lim, ha, hl, cl;
            is_step = $urandom_range(0, 3) == 0;
            lim = $urandom_range(0, 12);
            ha = $urandom_range(0, 2) == 0 ? $urandom_range(1, 12) : 0;
            hl = (!is_step && $urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
            cl = $urandom_range(0, 3) == 0 ? $urandom_range(1, 8) : 0;
            if (!is_step && lim == 0 && ha == 0 && hl == 0) hl = $urandom_range(1, 10);
            run_cmd(is_step, 1'($urandom_range(0, 1)), lim, ha, hl, cl, 1'($urandom_range(0, 1)));
            if (r % 8 == 7) idle_noop();
        end
        reset_mid_run();
        run_cmd(0, 0, 4, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
